counterexample_capture: RTL and testbench

COUNTEREXAMPLE_CAPTURE -- requirements
Module: counterexample_capture

---
 rtl/counterexample_capture.sv | 190 +++++++++++++++++++
 tb/tb_counterexample_capture.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counterexample_capture.sv
// counterexample_capture
// Watches two automata that are driven with the same input word and records
// the shortest prefix on which their acceptance outputs disagree.
//
// Ports
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-low clear of all state
//   arm       in   pulse: start (or restart) an equivalence run
//   word_rst  in   both automata are being reset: a new test word begins
//   step      in   in_bit is being applied to both automata this cycle
//   in_bit    in   symbol applied when step=1
//   out1      in   acceptance output of automaton 1
//   out2      in   acceptance output of automaton 2
//   busy      out  run in progress
//   done      out  run ended with a captured counterexample
//   mismatch  out  a counterexample is held
//   ce_len    out  counterexample length, 0..16
//   ce_bits   out  counterexample symbols, bit 0 = first symbol, upper bits 0
//   word_cnt  out  words started since arm, saturating at 255
//   ovf       out  sticky: some word ran past 16 symbols
module counterexample_capture (
   input  logic        clk,
   input  logic        reset,
   input  logic        arm,
   input  logic        word_rst,
   input  logic        step,
   input  logic        in_bit,
   input  logic        out1,
   input  logic        out2,
   output logic        busy,
   output logic        done,
   output logic        mismatch,
   output logic [4:0]  ce_len,
   output logic [15:0] ce_bits,
   output logic [7:0]  word_cnt,
   output logic        ovf
);

   localparam int unsigned PREFIX_W = 16;
   localparam int unsigned LEN_W    = 5;
   localparam int unsigned CNT_W    = 8;
   localparam int unsigned IDX_W    = 4;

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PREFIX_W);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ARMED    = 2'd1,
      ST_CAPTURED = 2'd2
   } state_e;

   state_e                state_q,    state_d;
   logic [PREFIX_W-1:0]   prefix_q,   prefix_d;
   logic [LEN_W-1:0]      plen_q,     plen_d;
   logic                  pend_q,     pend_d;
   logic                  mismatch_q, mismatch_d;
   logic [LEN_W-1:0]      ce_len_q,   ce_len_d;
   logic [PREFIX_W-1:0]   ce_bits_q,  ce_bits_d;
   logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
   logic                  ovf_q,      ovf_d;
   logic                  busy_q,     busy_d;
   logic                  done_q,     done_d;

   // Compare outcome for the pending sample (only meaningful when pend_q=1)
   logic                  differ_c;
   assign differ_c = out1 ^ out2;

   // Next-state and next-output logic
   always_comb begin
      state_d    = state_q;
      prefix_d   = prefix_q;
      plen_d     = plen_q;
      pend_d     = 1'b0;
      mismatch_d = mismatch_q;
      ce_len_d   = ce_len_q;
      ce_bits_d  = ce_bits_q;
      word_cnt_d = word_cnt_q;
      ovf_d      = ovf_q;

      unique case (state_q)
         ST_IDLE: begin
            if (arm) begin
               state_d    = ST_ARMED;
               prefix_d   = '0;
               plen_d     = '0;
               mismatch_d = 1'b0;
               ce_len_d   = '0;
               ce_bits_d  = '0;
               word_cnt_d = '0;
               ovf_d      = 1'b0;
            end
         end

         ST_ARMED: begin
            if (arm) begin
               state_d    = ST_ARMED;
               prefix_d   = '0;
               plen_d     = '0;
               mismatch_d = 1'b0;
               ce_len_d   = '0;
               ce_bits_d  = '0;
               word_cnt_d = '0;
               ovf_d      = 1'b0;
            end else if (pend_q && differ_c) begin
               // Prefix/length already reflect the event that raised the compare
               state_d    = ST_CAPTURED;
               mismatch_d = 1'b1;
               ce_len_d   = plen_q;
               ce_bits_d  = prefix_q;
            end else if (word_rst) begin
               // word_rst wins over a simultaneous step
               prefix_d = '0;
               plen_d   = '0;
               pend_d   = 1'b1;
               if (word_cnt_q != CNT_MAX) begin
                  word_cnt_d = word_cnt_q + CNT_W'(1);
               end
            end else if (step) begin
               if (plen_q < MAX_LEN) begin
                  prefix_d[IDX_W'(plen_q)] = in_bit;
                  plen_d                   = plen_q + LEN_W'(1);
                  pend_d                   = 1'b1;
               end else begin
                  // Full prefix: length stays at 16, so no compares until word_rst
                  ovf_d = 1'b1;
               end
            end
         end

         ST_CAPTURED: begin
            if (arm) begin
               state_d    = ST_ARMED;
               prefix_d   = '0;
               plen_d     = '0;
               mismatch_d = 1'b0;
               ce_len_d   = '0;
               ce_bits_d  = '0;
               word_cnt_d = '0;
               ovf_d      = 1'b0;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d == ST_ARMED);
      done_d = (state_d == ST_CAPTURED);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         prefix_q   <= '0;
         plen_q     <= '0;
         pend_q     <= 1'b0;
         mismatch_q <= 1'b0;
         ce_len_q   <= '0;
         ce_bits_q  <= '0;
         word_cnt_q <= '0;
         ovf_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         prefix_q   <= prefix_d;
         plen_q     <= plen_d;
         pend_q     <= pend_d;
         mismatch_q <= mismatch_d;
         ce_len_q   <= ce_len_d;
         ce_bits_q  <= ce_bits_d;
         word_cnt_q <= word_cnt_d;
         ovf_q      <= ovf_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign mismatch = mismatch_q;
   assign ce_len   = ce_len_q;
   assign ce_bits  = ce_bits_q;
   assign word_cnt = word_cnt_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_counterexample_capture.sv
// Testbench for counterexample_capture: directed scenarios plus a randomized
// run checked against a word-level reference model.
module tb_counterexample_capture;

   logic        clk;
   logic        reset;
   logic        arm;
   logic        word_rst;
   logic        step;
   logic        in_bit;
   logic        out1;
   logic        out2;
   logic        busy;
   logic        done;
   logic        mismatch;
   logic [4:0]  ce_len;
   logic [15:0] ce_bits;
   logic [7:0]  word_cnt;
   logic        ovf;

   int n_checks = 0;
   int n_errors = 0;

   counterexample_capture dut (
      .clk      (clk),
      .reset    (reset),
      .arm      (arm),
      .word_rst (word_rst),
      .step     (step),
      .in_bit   (in_bit),
      .out1     (out1),
      .out2     (out2),
      .busy     (busy),
      .done     (done),
      .mismatch (mismatch),
      .ce_len   (ce_len),
      .ce_bits  (ce_bits),
      .word_cnt (word_cnt),
      .ovf      (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: run mode, current word as a list of symbols, and
   // whether the previous cycle started a word or appended a symbol.
   int unsigned m_mode;      // 0 idle, 1 running, 2 captured
   bit          m_word[$];
   bit          m_cmp_due;
   bit          m_mis;
   int unsigned m_ce_len;
   logic [15:0] m_ce_bits;
   int unsigned m_words;
   bit          m_ovf;

   function automatic logic [15:0] pack_word();
      logic [15:0] v = '0;
      for (int i = 0; i < m_word.size(); i++) v[i] = m_word[i];
      return v;
   endfunction

   task automatic m_clear();
      m_mode = 0; m_word.delete(); m_cmp_due = 0; m_mis = 0;
      m_ce_len = 0; m_ce_bits = '0; m_words = 0; m_ovf = 0;
   endtask

   task automatic m_edge(input bit a, input bit w, input bit s, input bit b,
                         input bit o1, input bit o2);
      if (a) begin
         m_mode = 1; m_word.delete(); m_cmp_due = 0; m_mis = 0;
         m_ce_len = 0; m_ce_bits = '0; m_words = 0; m_ovf = 0;
      end else if (m_mode == 1) begin
         if (m_cmp_due && (o1 != o2)) begin
            m_mode = 2; m_mis = 1;
            m_ce_len = m_word.size(); m_ce_bits = pack_word();
            m_cmp_due = 0;
         end else begin
            m_cmp_due = 0;
            if (w) begin
               m_word.delete();
               if (m_words < 255) m_words++;
               m_cmp_due = 1;
            end else if (s) begin
               if (m_word.size() < 16) begin
                  m_word.push_back(b);
                  m_cmp_due = 1;
               end else begin
                  m_ovf = 1;
               end
            end
         end
      end
   endtask

   // One clock cycle: apply inputs after a falling edge, advance the model at
   // the rising edge, return just after the next falling edge.
   task automatic drive(input bit r, input bit a, input bit w, input bit s,
                        input bit b, input bit o1, input bit o2);
      reset = r; arm = a; word_rst = w; step = s; in_bit = b; out1 = o1; out2 = o2;
      if (!r) m_clear();
      @(posedge clk);
      if (!r) m_clear(); else m_edge(a, w, s, b, o1, o2);
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 0; arm = 0; word_rst = 0; step = 0; in_bit = 0; out1 = 0; out2 = 0;
      m_clear();
      @(negedge clk); @(negedge clk);
      n_checks++; if ({busy, done, mismatch, ovf} !== 4'b0) begin n_errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, mismatch, ovf}); end
      n_checks++; if ({ce_len, ce_bits, word_cnt} !== 29'd0) begin n_errors++; $display("FAIL reset_fields: got len=%0d bits=%h cnt=%0d want 0", ce_len, ce_bits, word_cnt); end
      // Idle ignores word_rst/step/compare inputs and stays idle until arm
      drive(1, 0, 1, 1, 1, 1, 0);
      drive(1, 0, 0, 1, 1, 0, 1);
      drive(1, 0, 0, 0, 0, 1, 0);
      n_checks++; if ({busy, done, mismatch, word_cnt} !== 11'd0) begin n_errors++; $display("FAIL idle_ignores: got busy=%b done=%b mis=%b cnt=%0d want 0", busy, done, mismatch, word_cnt); end
   endtask

   task automatic test_no_mismatch();
      drive(1, 1, 0, 0, 0, 0, 0);
      n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_errors++; $display("FAIL arm_busy: got busy=%b done=%b want 1 0", busy, done); end
      drive(1, 0, 1, 0, 0, 1, 1);
      drive(1, 0, 0, 1, 0, 0, 0);
      drive(1, 0, 0, 1, 1, 1, 1);
      drive(1, 0, 0, 0, 0, 0, 0);
      n_checks++; if ({busy, mismatch, word_cnt, ce_len} !== {1'b1, 1'b0, 8'd1, 5'd0}) begin n_errors++; $display("FAIL equal_word: got busy=%b mis=%b cnt=%0d len=%0d want 1 0 1 0", busy, mismatch, word_cnt, ce_len); end
   endtask

   task automatic test_capture();
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 1, 0, 0);
      drive(1, 0, 0, 1, 0, 1, 1);
      drive(1, 0, 0, 1, 1, 0, 0);
      n_checks++; if (mismatch !== 1'b0) begin n_errors++; $display("FAIL capture_latency: got mis=%b one cycle after step want 0", mismatch); end
      drive(1, 0, 0, 0, 0, 1, 0);
      n_checks++; if ({done, busy, mismatch, ce_len, ce_bits} !== {1'b1, 1'b0, 1'b1, 5'd3, 16'h0005}) begin n_errors++; $display("FAIL capture_101: got done=%b busy=%b mis=%b len=%0d bits=%h want 1 0 1 3 0005", done, busy, mismatch, ce_len, ce_bits); end
      // Captured state holds against further activity
      drive(1, 0, 1, 1, 1, 0, 1);
      drive(1, 0, 0, 1, 0, 1, 0);
      n_checks++; if ({done, mismatch, ce_len, ce_bits, word_cnt} !== {1'b1, 1'b1, 5'd3, 16'h0005, 8'd1}) begin n_errors++; $display("FAIL captured_hold: got done=%b mis=%b len=%0d bits=%h cnt=%0d want 1 1 3 0005 1", done, mismatch, ce_len, ce_bits, word_cnt); end
   endtask

   task automatic test_empty_word();
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 1);
      n_checks++; if ({mismatch, done, ce_len, ce_bits} !== {1'b1, 1'b1, 5'd0, 16'd0}) begin n_errors++; $display("FAIL empty_word: got mis=%b done=%b len=%0d bits=%h want 1 1 0 0000", mismatch, done, ce_len, ce_bits); end
   endtask

   task automatic test_overflow();
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 1, 1);
      for (int i = 0; i < 17; i++) drive(1, 0, 0, 1, 1'($urandom), 0, 0);
      n_checks++; if ({ovf, busy, mismatch, ce_len} !== {1'b1, 1'b1, 1'b0, 5'd0}) begin n_errors++; $display("FAIL overflow: got ovf=%b busy=%b mis=%b len=%0d want 1 1 0 0", ovf, busy, mismatch, ce_len); end
      // Steps past the limit raise no compare
      drive(1, 0, 0, 0, 0, 1, 0);
      n_checks++; if (mismatch !== 1'b0) begin n_errors++; $display("FAIL overflow_no_cmp: got mis=%b want 0", mismatch); end
      drive(1, 0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 1, 0);
      n_checks++; if ({done, mismatch, ce_len, ovf, word_cnt} !== {1'b1, 1'b1, 5'd0, 1'b1, 8'd2}) begin n_errors++; $display("FAIL overflow_then_cap: got done=%b mis=%b len=%0d ovf=%b cnt=%0d want 1 1 0 1 2", done, mismatch, ce_len, ovf, word_cnt); end
   endtask

   task automatic test_priority();
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 1, 1, 0, 0);
      drive(1, 0, 0, 0, 0, 1, 0);
      n_checks++; if ({mismatch, ce_len, ce_bits} !== {1'b1, 5'd0, 16'd0}) begin n_errors++; $display("FAIL wr_priority: got mis=%b len=%0d bits=%h want 1 0 0000", mismatch, ce_len, ce_bits); end
   endtask

   task automatic test_reset_midrun();
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 1, 0, 0);
      reset = 0; step = 0; out1 = 1; out2 = 0;
      m_clear();
      #1;
      n_checks++; if ({busy, done, mismatch, ce_len, ce_bits, word_cnt, ovf} !== 33'd0) begin n_errors++; $display("FAIL async_reset: got busy=%b done=%b mis=%b cnt=%0d want all 0", busy, done, mismatch, word_cnt); end
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0, 0, 1);
      n_checks++; if ({busy, done, mismatch, ce_len, ce_bits, word_cnt, ovf} !== 33'd0) begin n_errors++; $display("FAIL reset_no_capture: got busy=%b done=%b mis=%b len=%0d want all 0", busy, done, mismatch, ce_len); end
   endtask

   task automatic test_rearm();
      drive(1, 1, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 1, 0, 0);
      drive(1, 1, 0, 0, 0, 1, 0);
      n_checks++; if ({busy, mismatch, word_cnt} !== {1'b1, 1'b0, 8'd0}) begin n_errors++; $display("FAIL rearm_armed: got busy=%b mis=%b cnt=%0d want 1 0 0", busy, mismatch, word_cnt); end
      drive(1, 0, 1, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 1, 0);
      drive(1, 1, 0, 0, 0, 0, 0);
      n_checks++; if ({busy, done, mismatch, ce_len, word_cnt} !== {1'b1, 1'b0, 1'b0, 5'd0, 8'd0}) begin n_errors++; $display("FAIL rearm_captured: got busy=%b done=%b mis=%b len=%0d cnt=%0d want 1 0 0 0 0", busy, done, mismatch, ce_len, word_cnt); end
   endtask

   task automatic test_saturation();
      drive(1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 260; i++) drive(1, 0, 1, 0, 0, 1, 1);
      n_checks++; if (word_cnt !== 8'd255) begin n_errors++; $display("FAIL word_cnt_sat: got %0d want 255", word_cnt); end
   endtask

   task automatic test_random();
      bit r, a, w, s, b, o1, o2;
      logic [32:0] exp_v;
      drive(1, 1, 0, 0, 0, 0, 0);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         r  = ($urandom_range(0, 399) != 0);
         a  = ($urandom_range(0, 59) == 0);
         w  = ($urandom_range(0, 9) == 0);
         s  = ($urandom_range(0, 1) == 0);
         b  = 1'($urandom);
         o1 = 1'($urandom);
         o2 = ($urandom_range(0, 23) == 0) ? ~o1 : o1;
         drive(r, a, w, s, b, o1, o2);
         exp_v = {m_mode == 1, m_mode == 2, m_mis, 5'(m_ce_len), m_ce_bits, 8'(m_words), m_ovf};
         n_checks++;
         if ({busy, done, mismatch, ce_len, ce_bits, word_cnt, ovf} !== exp_v) begin
            n_errors++;
            $display("FAIL random cyc=%0d: got busy=%b done=%b mis=%b len=%0d bits=%h cnt=%0d ovf=%b want %b %b %b %0d %h %0d %b",
                     cyc, busy, done, mismatch, ce_len, ce_bits, word_cnt, ovf,
                     exp_v[32], exp_v[31], exp_v[30], exp_v[29:25], exp_v[24:9], exp_v[8:1], exp_v[0]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_no_mismatch();
      test_capture();
      test_empty_word();
      test_overflow();
      test_priority();
      test_reset_midrun();
      test_rearm();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
